instr_fetch_sequencer: RTL and testbench

Fetch/issue controller that owns the 6-bit program counter and sequences instruction fetch from program memory. It reads one opcode byte, then 0, 1 or 2 operand bytes as decoded from the opcode. It issues the assembled instruction to the execute unit over a valid/ready handshake and waits for completion. It then advances the PC, or loads a jump target. It sits between program memory and the execute stage of the 8086-style processor.

---
 rtl/instr_seq_pkg.sv | 31 +++
 rtl/instr_fetch_sequencer_pc_reg.sv | 33 +++
 rtl/instr_fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package instr_seq_pkg;

  localparam int              DEF_PC_W    = 6;
  localparam int              DEF_DATA_W  = 8;
  localparam logic [7:0]      DEF_HALT_OP = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_OP,
    ST_FETCH_A1,
    ST_FETCH_A2,
    ST_ISSUE,
    ST_EXEC,
    ST_HALT
  } state_t;

  // Operand byte count implied by the two top opcode bits.
  function automatic logic [1:0] op_count(input logic [7:0] opcode);
    logic [1:0] cnt;
    unique case (opcode[7:6])
      2'b11:   cnt = 2'd2;
      2'b10:   cnt = 2'd0;
      default: cnt = 2'd1;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/instr_fetch_sequencer_pc_reg.sv
// Program counter register with increment / load / hold control.
// Latency: inc or load takes effect on the next rising clock edge.
// Backpressure: none; holds its value whenever neither control is asserted.
//
// Ports: clock, reset (async active-low), inc (pc+1 modulo 2^PC_W),
//        load (pc <= load_val, wins over inc), load_val, pc.
module pc_reg #(
  parameter int PC_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else if (load) begin
      pc_q <= load_val;
    end else if (inc) begin
      // Natural overflow gives the required wrap from all-ones to zero.
      pc_q <= pc_q + 1'b1;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetches opcode plus 0..2 operand bytes, issues the instruction, waits for execution.
// Latency: (1 + operands) fetch cycles + 1 issue cycle + 1 exec cycle with zero-wait partners.
// Backpressure: mem_req holds until mem_ready; instr_valid holds until instr_ready; exec waits for exec_done.
//
// Ports: clock/reset (async active-low); start pulse leaves IDLE.
//        mem_req/mem_addr/mem_rdata/mem_ready : byte read port into program memory.
//        instr_valid/instr_ready/instr_*      : assembled instruction towards execute.
//        exec_done/jmp_taken/jmp_addr         : completion and optional jump from execute.
//        pc, halted                           : status.
module instr_fetch_sequencer
  import instr_seq_pkg::*;
#(
  parameter int                PC_W    = DEF_PC_W,
  parameter int                DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] HALT_OP = DEF_HALT_OP
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_arg1,
  output logic [DATA_W-1:0] instr_arg2,
  output logic [PC_W-1:0]   instr_pc,
  input  logic              exec_done,
  input  logic              jmp_taken,
  input  logic [PC_W-1:0]   jmp_addr,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  state_t state, state_nxt;

  logic [DATA_W-1:0] opcode_q;
  logic [DATA_W-1:0] arg1_q;
  logic [DATA_W-1:0] arg2_q;
  logic [PC_W-1:0]   instr_pc_q;
  logic              pc_inc;
  logic              pc_load;
  logic              xfer;

  // Operand count comes from the top bits of the opcode byte.
  logic [1:0] cnt_rdata;
  logic [1:0] cnt_latched;
  assign cnt_rdata   = op_count(mem_rdata[DATA_W-1 -: 8]);
  assign cnt_latched = op_count(opcode_q[DATA_W-1 -: 8]);

  pc_reg #(
    .PC_W(PC_W)
  ) u_pc_reg (
    .clock    (clock),
    .reset    (reset),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (jmp_addr),
    .pc       (pc)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (start) state_nxt = ST_FETCH_OP;
      ST_FETCH_OP: if (mem_ready) state_nxt = (cnt_rdata != 2'd0) ? ST_FETCH_A1 : ST_ISSUE;
      ST_FETCH_A1: if (mem_ready) state_nxt = (cnt_latched == 2'd2) ? ST_FETCH_A2 : ST_ISSUE;
      ST_FETCH_A2: if (mem_ready) state_nxt = ST_ISSUE;
      ST_ISSUE:    if (instr_ready) state_nxt = (opcode_q == HALT_OP) ? ST_HALT : ST_EXEC;
      ST_EXEC:     if (exec_done) state_nxt = ST_FETCH_OP;
      ST_HALT:     state_nxt = ST_HALT;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    pc_load     = 1'b0;
    unique case (state)
      ST_FETCH_OP, ST_FETCH_A1, ST_FETCH_A2: mem_req = 1'b1;
      ST_ISSUE:                             instr_valid = 1'b1;
      ST_EXEC:                              pc_load = exec_done & jmp_taken;
      ST_HALT:                              halted = 1'b1;
      default:                              ;
    endcase
  end

  assign xfer     = mem_req & mem_ready;
  // Every transferred byte advances the PC, operand bytes included.
  assign pc_inc   = xfer;
  assign mem_addr = pc;

  // Instruction assembly registers; stable through ISSUE because no fetch happens there.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opcode_q   <= '0;
      arg1_q     <= '0;
      arg2_q     <= '0;
      instr_pc_q <= '0;
    end else if (xfer) begin
      unique case (state)
        ST_FETCH_OP: begin
          opcode_q   <= mem_rdata;
          arg1_q     <= '0;
          arg2_q     <= '0;
          instr_pc_q <= pc;
        end
        ST_FETCH_A1: arg1_q <= mem_rdata;
        ST_FETCH_A2: arg2_q <= mem_rdata;
        default:     ;
      endcase
    end
  end

  assign instr_opcode = opcode_q;
  assign instr_arg1   = arg1_q;
  assign instr_arg2   = arg2_q;
  assign instr_pc     = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer with a 64-byte program memory model.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: mem_ready and instr_ready are stalled explicitly in selected vectors.
module tb_instr_fetch_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       mem_req;
  logic [5:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_arg1;
  logic [7:0] instr_arg2;
  logic [5:0] instr_pc;
  logic       exec_done;
  logic       jmp_taken;
  logic [5:0] jmp_addr;
  logic [5:0] pc;
  logic       halted;

  logic [7:0] mem [64];
  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  int reads[$];

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];

  instr_fetch_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_arg1   (instr_arg1),
    .instr_arg2   (instr_arg2),
    .instr_pc     (instr_pc),
    .exec_done    (exec_done),
    .jmp_taken    (jmp_taken),
    .jmp_addr     (jmp_addr),
    .pc           (pc),
    .halted       (halted)
  );

  // Record every byte transfer and every instruction handshake.
  always @(posedge clock) begin
    if (reset && mem_req && mem_ready) reads.push_back(int'(mem_addr));
    if (reset && instr_valid && instr_ready) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_valid(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!instr_valid && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!instr_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_reads(input string tag, input int n, input int first);
    chk({tag, "_nreads"}, reads.size(), n);
    for (int i = 0; i < n && i < reads.size(); i++)
      chk({tag, "_raddr"}, reads[i], (first + i) % 64);
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] op, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [5:0] ipc, input logic [5:0] npc);
    chk({tag, "_valid"}, instr_valid, 1);
    chk({tag, "_op"},    instr_opcode, op);
    chk({tag, "_a1"},    instr_arg1, a1);
    chk({tag, "_a2"},    instr_arg2, a2);
    chk({tag, "_ipc"},   instr_pc, ipc);
    chk({tag, "_pc"},    pc, npc);
  endtask

  task automatic finish_exec(input logic jt, input logic [5:0] ja);
    exec_done = 1'b1;
    jmp_taken = jt;
    jmp_addr  = ja;
    tick();
    exec_done = 1'b0;
    jmp_taken = 1'b0;
  endtask

  initial begin
    int cyc;
    int hs0;

    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0]  = 8'h83;
    mem[1]  = 8'h78;
    mem[2]  = 8'h2A;
    mem[3]  = 8'hFF;
    mem[4]  = 8'h11;
    mem[5]  = 8'h22;
    mem[62] = 8'hC1;
    mem[63] = 8'h05;

    reset       = 1'b0;
    start       = 1'b0;
    mem_ready   = 1'b1;
    instr_ready = 1'b1;
    exec_done   = 1'b0;
    jmp_taken   = 1'b0;
    jmp_addr    = '0;
    tick();
    tick();

    // Reset state
    chk("rst_pc",     pc, 0);
    chk("rst_req",    mem_req, 0);
    chk("rst_valid",  instr_valid, 0);
    chk("rst_op",     instr_opcode, 0);
    chk("rst_ipc",    instr_pc, 0);
    chk("rst_halted", halted, 0);

    reset = 1'b1;
    tick();
    chk("idle_req", mem_req, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    reads.delete();

    // 0-operand opcode 83 at address 0
    chk("t1_req",  mem_req, 1);
    chk("t1_addr", mem_addr, 0);
    wait_valid("t1", 20, cyc);
    chk("t1_lat", cyc, 1);
    chk_instr("t1", 8'h83, 8'h00, 8'h00, 6'd0, 6'd1);
    chk_reads("t1", 1, 0);
    tick();
    chk("t1_valid_drop", instr_valid, 0);
    finish_exec(1'b0, 6'd0);
    chk("t1_next_pc",   pc, 1);
    chk("t1_next_addr", mem_addr, 1);
    chk("t1_next_req",  mem_req, 1);

    // 1-operand opcode 78
    reads.delete();
    wait_valid("t2", 20, cyc);
    chk("t2_lat", cyc, 2);
    chk_instr("t2", 8'h78, 8'h2A, 8'h00, 6'd1, 6'd3);
    chk_reads("t2", 2, 1);
    tick();
    finish_exec(1'b0, 6'd0);
    chk("t2_next_addr", mem_addr, 3);

    // 2-operand opcode FF with memory stall on arg2 and issue backpressure
    reads.delete();
    instr_ready = 1'b0;
    tick();
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stall_req",   mem_req, 1);
      chk("t3_stall_addr",  mem_addr, 5);
      chk("t3_stall_valid", instr_valid, 0);
    end
    mem_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_instr("t3_hold", 8'hFF, 8'h11, 8'h22, 6'd3, 6'd6);
      if (i == 1) begin
        exec_done = 1'b1;
        jmp_taken = 1'b1;
        jmp_addr  = 6'd9;
      end
      if (i == 3) begin
        exec_done = 1'b0;
        jmp_taken = 1'b0;
      end
      tick();
    end
    chk("t3_ign_pc",    pc, 6);
    chk("t3_still_vld", instr_valid, 1);
    chk_reads("t3", 3, 3);
    instr_ready = 1'b1;
    tick();
    chk("t3_valid_drop", instr_valid, 0);
    mem[0] = 8'h06;
    finish_exec(1'b1, 6'd62);
    chk("t3_jmp_pc",   pc, 62);
    chk("t3_jmp_addr", mem_addr, 62);

    // 2-operand opcode C1 wrapping across the top of memory
    reads.delete();
    wait_valid("t4", 20, cyc);
    chk("t4_lat", cyc, 3);
    chk_instr("t4", 8'hC1, 8'h05, 8'h06, 6'd62, 6'd1);
    chk_reads("t4", 3, 62);
    tick();
    finish_exec(1'b0, 6'd0);
    chk("t4_next_pc", pc, 1);

    // Reset in the middle of an operand fetch
    tick();
    chk("t5_a1_addr", mem_addr, 2);
    chk("t5_a1_op",   instr_opcode, 8'h78);
    reset = 1'b0;
    #1;
    chk("t5_rst_pc",    pc, 0);
    chk("t5_rst_req",   mem_req, 0);
    chk("t5_rst_valid", instr_valid, 0);
    chk("t5_rst_op",    instr_opcode, 0);
    chk("t5_rst_ipc",   instr_pc, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("t5_idle_req", mem_req, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    reads.delete();
    chk("t5_restart_addr", mem_addr, 0);
    wait_valid("t5", 20, cyc);
    chk("t5_lat", cyc, 2);
    chk_instr("t5", 8'h06, 8'h78, 8'h00, 6'd0, 6'd2);
    tick();
    mem[10] = 8'h80;
    finish_exec(1'b1, 6'd10);
    chk("t5_jmp_pc", pc, 10);

    // Halt opcode
    reads.delete();
    hs0 = hs_cnt;
    wait_valid("t6", 20, cyc);
    chk("t6_lat", cyc, 1);
    chk_instr("t6", 8'h80, 8'h00, 8'h00, 6'd10, 6'd11);
    chk("t6_pre_halted", halted, 0);
    tick();
    chk("t6_halted", halted, 1);
    chk("t6_req",    mem_req, 0);
    chk("t6_valid",  instr_valid, 0);
    chk("t6_hs",     hs_cnt - hs0, 1);
    start     = 1'b1;
    exec_done = 1'b1;
    jmp_taken = 1'b1;
    jmp_addr  = 6'd20;
    tick();
    start     = 1'b0;
    exec_done = 1'b0;
    jmp_taken = 1'b0;
    tick();
    tick();
    chk("t6_stay_halted", halted, 1);
    chk("t6_stay_req",    mem_req, 0);
    chk("t6_stay_valid",  instr_valid, 0);
    chk("t6_stay_pc",     pc, 11);
    chk("t6_stay_hs",     hs_cnt - hs0, 1);
    chk_reads("t6", 1, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
